// File: rtl/pending_request_queue.sv
// Per-source saturating request accumulator feeding a one-hot priority encoder.
// Each lane counts outstanding requests; one acknowledged grant retires one request.

module pending_request_lane #(
  parameter int COUNT_WIDTH = 3
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clear_overflow,
  output logic o_pending,
  output logic o_full,
  output logic o_overflow
);
  localparam logic [COUNT_WIDTH-1:0] MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] ONE = 1;

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q & ~i_clear_overflow;
    // A simultaneous inc and dec cancel out, even at max, so never flags overflow.
    if (i_inc && !i_dec) begin
      if (count_q == MAX) overflow_d = 1'b1;
      else                count_d    = count_q + ONE;
    end else if (i_dec && !i_inc) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_pending  = (count_q != '0);
  assign o_full     = (count_q == MAX);
  assign o_overflow = overflow_q;
endmodule

module pending_request_queue #(
  parameter int WIDTH       = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_req,
  input  logic [WIDTH-1:0] i_grant,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_clear_overflow,
  output logic [WIDTH-1:0] o_pending,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_full,
  output logic [WIDTH-1:0] o_overflow,
  output logic             o_grant_error
);
  logic             ack_ok;
  logic [WIDTH-1:0] dec;
  logic             grant_error_q, grant_error_d;

  // Only a one-hot grant pointing at a non-empty source may retire a request.
  always_comb begin
    ack_ok        = i_ack & $onehot(i_grant) & (|(i_grant & o_pending));
    dec           = {WIDTH{ack_ok}} & i_grant;
    grant_error_d = i_ack & ~ack_ok;
  end

  pending_request_lane #(.COUNT_WIDTH(COUNT_WIDTH)) u_lane [WIDTH-1:0] (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_inc            (i_req),
    .i_dec            (dec),
    .i_clear_overflow (i_clear_overflow),
    .o_pending        (o_pending),
    .o_full           (o_full),
    .o_overflow       (o_overflow)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) grant_error_q <= 1'b0;
    else         grant_error_q <= grant_error_d;
  end

  assign o_valid       = |o_pending;
  assign o_grant_error = grant_error_q;
endmodule

// File: tb/tb_pending_request_queue.sv
// Scoreboard bench: driver applies stimulus and queues model predictions; monitor compares.

module tb_pending_request_queue;
  localparam int W   = 4;
  localparam int CW  = 3;
  localparam int MAX = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         i_reset;
  logic [W-1:0] i_req, i_grant, i_clear_overflow;
  logic         i_ack;
  logic [W-1:0] o_pending, o_full, o_overflow;
  logic         o_valid, o_grant_error;

  always #5 clk = ~clk;

  pending_request_queue #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .i_req            (i_req),
    .i_grant          (i_grant),
    .i_ack            (i_ack),
    .i_clear_overflow (i_clear_overflow),
    .o_pending        (o_pending),
    .o_valid          (o_valid),
    .o_full           (o_full),
    .o_overflow       (o_overflow),
    .o_grant_error    (o_grant_error)
  );

  typedef struct packed {
    logic [W-1:0] pending;
    logic         valid;
    logic [W-1:0] full;
    logic [W-1:0] overflow;
    logic         grant_error;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain integer counts per source.
  int cnt[W];
  bit ovf[W];
  bit gerr;

  task automatic model_step(input logic [W-1:0] req, grant, input logic ack,
                            input logic [W-1:0] clr, input logic rst);
    int  ones, g, nxt;
    bit  good;
    if (rst) begin
      for (int k = 0; k < W; k++) begin cnt[k] = 0; ovf[k] = 0; end
      gerr = 0;
      return;
    end
    ones = $countones(grant);
    g = 0;
    for (int k = 0; k < W; k++) if (grant[k]) g = k;
    good = ack && ones == 1 && cnt[g] > 0;
    gerr = ack && !good;
    for (int k = 0; k < W; k++) begin
      nxt = cnt[k] + int'(req[k]) - ((good && grant[k]) ? 1 : 0);
      if (nxt > MAX) ovf[k] = 1;
      else begin
        cnt[k] = nxt;
        if (clr[k]) ovf[k] = 0;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    for (int k = 0; k < W; k++) begin
      e.pending[k]  = cnt[k] > 0;
      e.full[k]     = cnt[k] == MAX;
      e.overflow[k] = ovf[k];
    end
    e.valid       = |e.pending;
    e.grant_error = gerr;
    return e;
  endfunction

  function automatic logic [W-1:0] model_grant();
    for (int k = 0; k < W; k++) if (cnt[k] > 0) return W'(1 << k);
    return '0;
  endfunction

  task automatic cyc(input logic [W-1:0] req, grant, input logic ack,
                     input logic [W-1:0] clr, input logic rst);
    @(negedge clk);
    i_req = req; i_grant = grant; i_ack = ack; i_clear_overflow = clr; i_reset = rst;
    model_step(req, grant, ack, clr, rst);
    exp_q.push_back(model_out());
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Monitor: after each active edge, compare against the oldest prediction.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pending",     o_pending,            e.pending);
      chk("valid",       W'(o_valid),          W'(e.valid));
      chk("full",        o_full,               e.full);
      chk("overflow",    o_overflow,           e.overflow);
      chk("grant_error", W'(o_grant_error),    W'(e.grant_error));
    end
  end

  initial begin
    logic [W-1:0] r, g, c;
    logic         a;
    i_reset = 1'b1; i_req = '0; i_grant = '0; i_ack = 1'b0; i_clear_overflow = '0;
    for (int k = 0; k < W; k++) begin cnt[k] = 0; ovf[k] = 0; end
    gerr = 0;

    cyc('0, '0, 0, '0, 1);
    cyc('0, '0, 0, '0, 1);
    // Basic request / retire
    cyc(4'b0101, '0, 0, '0, 0);
    cyc('0, 4'b0001, 1, '0, 0);
    cyc('0, 4'b0100, 1, '0, 0);
    cyc('0, '0, 0, '0, 0);
    // Saturation and sticky overflow on source 2
    for (int i = 0; i < 9; i++) cyc(4'b0100, '0, 0, '0, 0);
    cyc('0, '0, 0, '0, 0);
    cyc('0, '0, 0, '0, 0);
    cyc('0, '0, 0, 4'b0100, 0);
    for (int i = 0; i < 7; i++) cyc('0, 4'b0100, 1, '0, 0);
    cyc('0, '0, 0, '0, 0);
    // Request + ack at max on source 1 is not an overflow
    for (int i = 0; i < 7; i++) cyc(4'b0010, '0, 0, '0, 0);
    cyc(4'b0010, 4'b0010, 1, '0, 0);
    cyc('0, '0, 0, '0, 0);
    // Invalid grants
    cyc('0, 4'b0110, 1, '0, 0);
    cyc('0, 4'b1000, 1, '0, 0);
    cyc('0, '0, 1, '0, 0);
    cyc('0, '0, 0, '0, 0);
    // Reset overriding traffic
    cyc('0, '0, 0, '0, 1);
    cyc(4'b1111, '0, 0, '0, 0);
    cyc(4'b0110, '0, 0, '0, 0);
    cyc(4'b0100, '0, 0, '0, 0);
    cyc(4'b1111, 4'b0001, 1, '0, 1);
    cyc('0, '0, 0, '0, 0);
    cyc(4'b0001, '0, 0, '0, 0);
    cyc('0, '0, 0, '0, 0);

    // Random traffic: mostly encoder-correct grants, some malformed ones
    for (int i = 0; i < 600; i++) begin
      r = W'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & W'($urandom);
      a = ($urandom_range(0, 3) != 0);
      g = ($urandom_range(0, 7) == 0) ? W'($urandom) : model_grant();
      c = ($urandom_range(0, 9) == 0) ? W'($urandom) : '0;
      cyc(r, g, a, c, $urandom_range(0, 99) == 0);
    end
    cyc('0, '0, 0, '0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pending_request_queue.md
# pending_request_queue

Per-source request accumulator that sits directly upstream of the one-hot priority encoder. It turns single-cycle request pulses from WIDTH sources into a registered pending vector that drives the encoder input. It takes the encoder's one-hot grant back together with a consumer acknowledge, and retires exactly one queued request from the granted source per acknowledged cycle. Each source has a saturating counter, so back-to-back pulses are not lost while the source waits for service.

## Interface
- WIDTH, 4: number of request sources; must be ≥ 1.
- COUNT_WIDTH, 3: bits per source counter; max queued per source = 2^COUNT_WIDTH − 1; must be ≥ 1.

- i_clock  input  1  single clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_req  input  WIDTH  bit k high for one cycle = one new request from source k; multiple bits may be high together.
- i_grant  input  WIDTH  one-hot grant from the priority encoder, computed from o_pending.
- i_ack  input  1  consumer accepted the grant presented this cycle.
- o_pending  output  WIDTH  bit k = (count_k != 0); feeds the encoder input.
- o_valid  output  1  OR-reduction of o_pending.
- o_full  output  WIDTH  bit k = count_k at maximum.
- o_overflow  output  WIDTH  sticky; bit k set when a source-k request was dropped.
- i_clear_overflow  input  WIDTH  bit k clears o_overflow[k].
- o_grant_error  output  1  registered one-cycle pulse flagging an invalid acknowledged grant.

## Operation
- State per source k:
  - count_k: COUNT_WIDTH-bit unsigned.
  - overflow_k: 1 bit.
- Global state: one grant_error register.
- Decrement enable dec_k = i_ack AND i_grant[k] AND (count_k != 0) AND (i_grant is exactly one-hot).
- Increment inc_k = i_req[k].
- Count update each cycle, per source:
  - inc_k and not dec_k, count_k < max: count_k + 1.
  - inc_k and not dec_k, count_k == max: count_k unchanged; overflow_k set.
  - dec_k and not inc_k: count_k − 1.
  - inc_k and dec_k: count_k unchanged, including at max. This is not an overflow.
  - neither: unchanged.
- No wrap-around in either direction:
  - the counter never passes max;
  - a decrement at zero cannot happen, because dec_k requires count_k != 0.
- Overflow update, per bit: set-on-overflow takes priority over i_clear_overflow[k] in the same cycle, so the bit stays 1.
- Grant error: o_grant_error next cycle = i_ack AND (i_grant has zero bits or ≥2 bits set, or the granted source's count is 0). No counter changes on an errored ack.
- i_grant is ignored whenever i_ack is low; any value is legal then.
- o_pending, o_valid and o_full are combinational decodes of the count registers only. There is no combinational path from any input to any output.
- Sources are fully independent; simultaneous requests on all WIDTH sources in one cycle are all accepted.

## Timing
- Reset, when i_reset is high at the rising edge:
  - all counts = 0, o_overflow = 0, o_grant_error = 0;
  - therefore o_pending = 0, o_valid = 0, o_full = 0 from the following cycle;
  - reset overrides every other input in that cycle, including requests and acks arriving mid-operation; those are discarded.
- Request latency: i_req[k] at edge n makes o_pending[k] high after edge n when count was 0. One cycle.
- Acknowledge latency: i_ack at edge n decrements the count after edge n. The encoder sees the updated o_pending in cycle n+1, so the same source is granted again only if its count is still nonzero.
- Throughput: one retirement per cycle overall, at most one per source per cycle. A source with count 1 that is acked and requested in the same cycle stays pending with count 1.
- o_grant_error is high for exactly the one cycle after the offending ack.

## Test plan
- Reset, then i_req=4'b0101 for one cycle, then ack with i_grant=4'b0001 → o_pending=4'b0101 next cycle; after the ack, o_pending=4'b0100 and o_valid=1; a second ack with i_grant=4'b0100 → o_pending=0, o_valid=0.
- Source 2 pulsed 9 times consecutively with COUNT_WIDTH=3, no acks → count 7, o_full[2]=1 from the 7th pulse onward, o_overflow[2]=1 after the 8th pulse; o_overflow[2] stays set until i_clear_overflow[2]; seven acks on source 2 then drain it to o_pending[2]=0.
- Source 1 at count 7 receives i_req[1] and an ack with i_grant=4'b0010 in the same cycle → count stays 7, o_overflow[1] stays 0.
- Ack with i_grant=4'b0110, then ack with i_grant=4'b1000 while count_3=0 → o_grant_error pulses one cycle after each; all counts unchanged.
- Load counts {1,2,3,1} on sources 0–3, assert i_reset for one cycle alongside i_req=4'b1111 and i_ack=1 → all outputs 0 the next cycle; o_pending rises only after a fresh request.
